// File: rtl/mpsoc_msp430_glip_bb_bridge.sv
// GLIP 16-bit command stream to Blackbone external-bus bridge.
// Writes are acknowledged with one word; reads stream back hi/lo word pairs.
`timescale 1ns/1ps
module mpsoc_msp430_glip_bb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int ADDR_INCR  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           glip_in_data,
    input  logic                  glip_in_valid,
    output logic                  glip_in_ready,
    output logic [15:0]           glip_out_data,
    output logic                  glip_out_valid,
    input  logic                  glip_out_ready,
    output logic [ADDR_WIDTH-1:0] bb_ext_addr_o,
    output logic [31:0]           bb_ext_din_o,
    output logic                  bb_ext_en_o,
    output logic [3:0]            bb_ext_we_o,
    input  logic [31:0]           bb_ext_dout_i,
    output logic                  busy_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_WD_HI, S_WD_LO, S_WR_ISSUE,
        S_WACK, S_RD_ISSUE, S_RD_CAP, S_RD_HI, S_RD_LO, S_ERR
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_write;
    logic [7:0]            r_len;
    logic [8:0]            r_cnt;
    logic [15:0]           r_addr_hi;
    logic [15:0]           r_wd_hi;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_din;
    logic [31:0]           r_rdata;

    logic                  w_in_rdy;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_hdr_err;
    logic [31:0]           w_addr_full;

    assign w_addr_full   = {r_addr_hi, glip_in_data};
    assign w_hdr_err     = |glip_in_data[14:8];
    // Nothing is accepted while reset is held, so all outputs read 0 then.
    assign glip_in_ready = w_in_rdy & rst_n;
    assign w_in_fire     = glip_in_valid & glip_in_ready;
    assign w_out_fire    = glip_out_valid & glip_out_ready;

    assign bb_ext_addr_o = r_addr;
    assign bb_ext_din_o  = r_din;
    assign busy_o        = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_write   <= 1'b0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_addr_hi <= '0;
            r_wd_hi   <= '0;
            r_addr    <= '0;
            r_din     <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (w_in_fire) begin
                    r_write <= glip_in_data[15];
                    r_len   <= glip_in_data[7:0];
                    // LEN of 0 encodes 256 words.
                    r_cnt   <= {(glip_in_data[7:0] == 8'd0), glip_in_data[7:0]};
                end
                S_ADDR_HI: if (w_in_fire) r_addr_hi <= glip_in_data;
                S_ADDR_LO: if (w_in_fire) r_addr <= w_addr_full[ADDR_WIDTH-1:0];
                S_WD_HI:   if (w_in_fire) r_wd_hi <= glip_in_data;
                S_WD_LO:   if (w_in_fire) r_din <= {r_wd_hi, glip_in_data};
                S_WR_ISSUE, S_RD_ISSUE: begin
                    r_addr <= r_addr + ADDR_WIDTH'(ADDR_INCR);
                    r_cnt  <= r_cnt - 9'd1;
                end
                S_RD_CAP: r_rdata <= bb_ext_dout_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next         = r_state;
        w_in_rdy       = 1'b0;
        glip_out_valid = 1'b0;
        glip_out_data  = '0;
        bb_ext_en_o    = 1'b0;
        bb_ext_we_o    = '0;
        case (r_state)
            S_IDLE: begin
                w_in_rdy = 1'b1;
                if (glip_in_valid) w_next = w_hdr_err ? S_ERR : S_ADDR_HI;
            end
            S_ADDR_HI: begin
                w_in_rdy = 1'b1;
                if (glip_in_valid) w_next = S_ADDR_LO;
            end
            S_ADDR_LO: begin
                w_in_rdy = 1'b1;
                if (glip_in_valid) w_next = r_write ? S_WD_HI : S_RD_ISSUE;
            end
            S_WD_HI: begin
                w_in_rdy = 1'b1;
                if (glip_in_valid) w_next = S_WD_LO;
            end
            S_WD_LO: begin
                w_in_rdy = 1'b1;
                if (glip_in_valid) w_next = S_WR_ISSUE;
            end
            S_WR_ISSUE: begin
                bb_ext_en_o = 1'b1;
                bb_ext_we_o = 4'hF;
                w_next      = (r_cnt == 9'd1) ? S_WACK : S_WD_HI;
            end
            S_WACK: begin
                glip_out_valid = 1'b1;
                glip_out_data  = {8'h80, r_len};
                if (w_out_fire) w_next = S_IDLE;
            end
            S_RD_ISSUE: begin
                bb_ext_en_o = 1'b1;
                w_next      = S_RD_CAP;
            end
            S_RD_CAP: w_next = S_RD_HI;
            S_RD_HI: begin
                glip_out_valid = 1'b1;
                glip_out_data  = r_rdata[31:16];
                if (w_out_fire) w_next = S_RD_LO;
            end
            S_RD_LO: begin
                glip_out_valid = 1'b1;
                glip_out_data  = r_rdata[15:0];
                // Counter was already decremented at RD_ISSUE.
                if (w_out_fire) w_next = (r_cnt == 9'd0) ? S_IDLE : S_RD_ISSUE;
            end
            S_ERR: begin
                glip_out_valid = 1'b1;
                glip_out_data  = {8'hE0, r_len};
                if (w_out_fire) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mpsoc_msp430_glip_bb_bridge.sv
// Directed bench for the GLIP to Blackbone bridge: vector table plus
// backpressure, reset-abort and LEN=0 sequences.
`timescale 1ns/1ps
module tb_mpsoc_msp430_glip_bb_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] glip_in_data = '0;
    logic        glip_in_valid = 1'b0;
    logic        glip_in_ready;
    logic [15:0] glip_out_data;
    logic        glip_out_valid;
    logic        glip_out_ready = 1'b1;
    logic [31:0] bb_ext_addr_o;
    logic [31:0] bb_ext_din_o;
    logic        bb_ext_en_o;
    logic [3:0]  bb_ext_we_o;
    logic [31:0] bb_ext_dout_i = '0;
    logic        busy_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    mpsoc_msp430_glip_bb_bridge #(.ADDR_WIDTH(32), .ADDR_INCR(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .glip_in_data  (glip_in_data),
        .glip_in_valid (glip_in_valid),
        .glip_in_ready (glip_in_ready),
        .glip_out_data (glip_out_data),
        .glip_out_valid(glip_out_valid),
        .glip_out_ready(glip_out_ready),
        .bb_ext_addr_o (bb_ext_addr_o),
        .bb_ext_din_o  (bb_ext_din_o),
        .bb_ext_en_o   (bb_ext_en_o),
        .bb_ext_we_o   (bb_ext_we_o),
        .bb_ext_dout_i (bb_ext_dout_i),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    // Memory model: unknown addresses read back as the inverted address.
    logic [31:0] mem [logic [31:0]];
    always @(posedge clk) begin
        if (bb_ext_en_o && bb_ext_we_o == 4'h0)
            bb_ext_dout_i <= mem.exists(bb_ext_addr_o) ? mem[bb_ext_addr_o] : ~bb_ext_addr_o;
    end

    logic [31:0] acc_addr [$];
    logic [3:0]  acc_we   [$];
    logic [31:0] acc_din  [$];
    logic [15:0] resp     [$];

    always @(negedge clk) begin
        if (bb_ext_en_o) begin
            acc_addr.push_back(bb_ext_addr_o);
            acc_we.push_back(bb_ext_we_o);
            acc_din.push_back(bb_ext_din_o);
        end
        if (glip_out_valid && glip_out_ready) resp.push_back(glip_out_data);
    end

    typedef struct {
        logic [15:0]       hdr;
        logic [31:0]       addr;
        logic              send_addr;
        logic [1:0][31:0]  data;
        int unsigned       n_acc;
        logic [1:0][31:0]  exp_addr;
        logic [3:0]        exp_we;
        int unsigned       n_resp;
        logic [3:0][15:0]  exp_resp;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input logic [15:0] hdr, input logic [31:0] addr,
                                input logic sa, input logic [31:0] d0, input logic [31:0] d1,
                                input int unsigned nacc, input logic [31:0] a0,
                                input logic [31:0] a1, input logic [3:0] we,
                                input int unsigned nr, input logic [15:0] r0,
                                input logic [15:0] r1, input logic [15:0] r2,
                                input logic [15:0] r3);
        vec_t v;
        v.hdr = hdr; v.addr = addr; v.send_addr = sa;
        v.data[0] = d0; v.data[1] = d1;
        v.n_acc = nacc; v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_we = we;
        v.n_resp = nr;
        v.exp_resp[0] = r0; v.exp_resp[1] = r1; v.exp_resp[2] = r2; v.exp_resp[3] = r3;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        acc_addr.delete(); acc_we.delete(); acc_din.delete(); resp.delete();
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [15:0] w);
        int unsigned n = 0;
        glip_in_data  = w;
        glip_in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!glip_in_ready && n < 50);
        if (!glip_in_ready) check($sformatf("in_ready timeout word %h", w), 32'(glip_in_ready), 32'd1);
        @(posedge clk);
        #1;
        glip_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_o && n < 3000);
        if (busy_o) check({nm, " idle timeout"}, 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        clear_mon();
        if (!v.hdr[15]) begin
            mem[v.addr] = v.data[0];
            if (v.n_acc > 1) mem[v.addr + 32'd4] = v.data[1];
        end
        send_word(v.hdr);
        if (v.send_addr) begin
            send_word(v.addr[31:16]);
            send_word(v.addr[15:0]);
            if (v.hdr[15]) begin
                for (int i = 0; i < int'(v.n_acc); i++) begin
                    send_word(v.data[i][31:16]);
                    send_word(v.data[i][15:0]);
                end
            end
        end
        wait_idle($sformatf("v%0d", k));
        check($sformatf("v%0d acc count", k), acc_addr.size(), v.n_acc);
        for (int i = 0; i < int'(v.n_acc); i++) begin
            if (i < acc_addr.size()) begin
                check($sformatf("v%0d acc%0d addr", k, i), acc_addr[i], v.exp_addr[i]);
                check($sformatf("v%0d acc%0d we", k, i), 32'(acc_we[i]), 32'(v.exp_we));
                if (v.hdr[15]) check($sformatf("v%0d acc%0d din", k, i), acc_din[i], v.data[i]);
            end
        end
        check($sformatf("v%0d resp count", k), resp.size(), v.n_resp);
        for (int i = 0; i < int'(v.n_resp); i++) begin
            if (i < resp.size())
                check($sformatf("v%0d resp%0d", k, i), 32'(resp[i]), 32'(v.exp_resp[i]));
        end
    endtask

    task automatic check_zero_outputs(input string nm);
        check({nm, " en"},       32'(bb_ext_en_o),    32'd0);
        check({nm, " we"},       32'(bb_ext_we_o),    32'd0);
        check({nm, " addr"},     bb_ext_addr_o,       32'd0);
        check({nm, " din"},      bb_ext_din_o,        32'd0);
        check({nm, " out_vld"},  32'(glip_out_valid), 32'd0);
        check({nm, " out_data"}, 32'(glip_out_data),  32'd0);
        check({nm, " in_rdy"},   32'(glip_in_ready),  32'd0);
        check({nm, " busy"},     32'(busy_o),         32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(16'h8001, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 32'h0, 1,
                     32'h0000_0100, 32'h0, 4'hF, 1, 16'h8001, 16'h0, 16'h0, 16'h0);
        vecs[1] = mk(16'h0002, 32'h0000_0100, 1'b1, 32'h1122_3344, 32'h5566_7788, 2,
                     32'h0000_0100, 32'h0000_0104, 4'h0, 4, 16'h1122, 16'h3344, 16'h5566, 16'h7788);
        vecs[2] = mk(16'h4003, 32'h0, 1'b0, 32'h0, 32'h0, 0,
                     32'h0, 32'h0, 4'h0, 1, 16'hE003, 16'h0, 16'h0, 16'h0);
        vecs[3] = mk(16'h8001, 32'h0000_0200, 1'b1, 32'hCAFE_F00D, 32'h0, 1,
                     32'h0000_0200, 32'h0, 4'hF, 1, 16'h8001, 16'h0, 16'h0, 16'h0);
        vecs[4] = mk(16'h8002, 32'hFFFF_FFFC, 1'b1, 32'h0123_4567, 32'h89AB_CDEF, 2,
                     32'hFFFF_FFFC, 32'h0000_0000, 4'hF, 1, 16'h8002, 16'h0, 16'h0, 16'h0);
        vecs[5] = mk(16'h0002, 32'hFFFF_FFFC, 1'b1, 32'h0123_4567, 32'h89AB_CDEF, 2,
                     32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 4, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF);
        vecs[6] = mk(16'h0105, 32'h0, 1'b0, 32'h0, 32'h0, 0,
                     32'h0, 32'h0, 4'h0, 1, 16'hE005, 16'h0, 16'h0, 16'h0);
        vecs[7] = mk(16'h0001, 32'h0000_0010, 1'b1, 32'hA5A5_5A5A, 32'h0, 1,
                     32'h0000_0010, 32'h0, 4'h0, 2, 16'hA5A5, 16'h5A5A, 16'h0, 16'h0);

        // Reset state
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle in_ready", 32'(glip_in_ready), 32'd1);

        for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

        // Backpressure: stall at RD_HI for 10 cycles
        clear_mon();
        mem[32'h100] = 32'h1122_3344;
        mem[32'h104] = 32'h5566_7788;
        glip_out_ready = 1'b0;
        send_word(16'h0002);
        send_word(16'h0000);
        send_word(16'h0100);
        begin
            int unsigned n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!glip_out_valid && n < 50);
        end
        check("bp first valid", 32'(glip_out_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("bp c%0d valid", c), 32'(glip_out_valid), 32'd1);
            check($sformatf("bp c%0d data", c), 32'(glip_out_data), 32'h1122);
            check($sformatf("bp c%0d en", c), 32'(bb_ext_en_o), 32'd0);
        end
        check("bp acc during stall", acc_addr.size(), 32'd1);
        @(posedge clk);
        #1;
        glip_out_ready = 1'b1;
        wait_idle("bp");
        check("bp acc count", acc_addr.size(), 32'd2);
        if (acc_addr.size() == 2) check("bp acc1 addr", acc_addr[1], 32'h0000_0104);
        check("bp resp count", resp.size(), 32'd4);
        if (resp.size() == 4) begin
            check("bp resp0", 32'(resp[0]), 32'h1122);
            check("bp resp1", 32'(resp[1]), 32'h3344);
            check("bp resp2", 32'(resp[2]), 32'h5566);
            check("bp resp3", 32'(resp[3]), 32'h7788);
        end

        // Async reset in the middle of a write
        clear_mon();
        send_word(16'h8001);
        send_word(16'h0000);
        send_word(16'h0300);
        send_word(16'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid rst no access", acc_addr.size(), 32'd0);
        check("mid rst no resp", resp.size(), 32'd0);
        @(posedge clk);
        #1;
        run_vec(vecs[7], 17);

        // LEN=0 read: 256 accesses, 512 response words
        clear_mon();
        send_word(16'h0000);
        send_word(16'h0001);
        send_word(16'h0000);
        wait_idle("len0");
        check("len0 acc count", acc_addr.size(), 32'd256);
        check("len0 resp count", resp.size(), 32'd512);
        if (acc_addr.size() == 256) check("len0 last addr", acc_addr[255], 32'h0001_03FC);
        if (resp.size() == 512) begin
            check("len0 resp0", 32'(resp[0]), 32'hFFFE);
            check("len0 resp1", 32'(resp[1]), 32'hFFFF);
            check("len0 resp510", 32'(resp[510]), 32'hFFFE);
            check("len0 resp511", 32'(resp[511]), 32'hFC03);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
